// File: rtl/dotprod_seq_ctrl_if.sv
// Job, operand and result channels of the dot-product sequencer.
// Every channel is valid/ready: a transfer occurs on a rising clock edge when valid and ready are both high.
interface dotprod_seq_ctrl_if #(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int MAX_LEN    = 64,
  parameter int ACC_SIZE   = 32
) ();
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                                  job_valid_i;
  logic                                  job_ready_o;
  logic [LEN_W-1:0]                      job_len_i;
  logic                                  op_valid_i;
  logic                                  op_ready_o;
  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0]  op_0_i;
  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0]  op_1_i;
  logic                                  res_valid_o;
  logic                                  res_ready_i;
  logic [ACC_SIZE-1:0]                   res_data_o;

  modport slave (
    input  job_valid_i, job_len_i, op_valid_i, op_0_i, op_1_i, res_ready_i,
    output job_ready_o, op_ready_o, res_valid_o, res_data_o
  );

  modport master (
    output job_valid_i, job_len_i, op_valid_i, op_0_i, op_1_i, res_ready_i,
    input  job_ready_o, op_ready_o, res_valid_o, res_data_o
  );
endinterface

// File: rtl/dotprod_seq_ctrl.sv
// Sequencer for the combinational signed multiplier array: feeds operand beats, reduces partial products, accumulates.
// Optional ACC_SAT_EN: saturating accumulate instead of wrapping modulo 2^ACC_SIZE.
module dotprod_seq_ctrl #(
  parameter int IN_SIZE_0  = 4,
  parameter int IN_SIZE_1  = 8,
  parameter int ARRAY_SIZE = 8,
  parameter int MAX_LEN    = 64,
  parameter int ACC_SIZE   = 32,
  localparam int PP_PER_MUL   = (IN_SIZE_1 + 2) / 3,
  localparam int PP_PER_ARRAY = PP_PER_MUL * ARRAY_SIZE,
  localparam int PP_SIZE      = IN_SIZE_0 + IN_SIZE_1,
  localparam int LEN_W        = $clog2(MAX_LEN + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  dotprod_seq_ctrl_if.slave                      bus,
  output logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0]   arr_in_0_o,
  output logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0]   arr_in_1_o,
  input  logic [PP_PER_ARRAY-1:0][PP_SIZE-1:0]   arr_pp_i,
  output logic                                   busy_o,
  output logic [1:0]                             dbg_state_o
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef ACC_SAT_EN
  localparam int SUM_W = ACC_SIZE + $clog2(ARRAY_SIZE) + 1;
`else
  localparam int SUM_W = ACC_SIZE;
`endif

  logic [1:0]                           state_q, state_d;
  logic [LEN_W-1:0]                     len_q, len_d;
  logic [LEN_W-1:0]                     cnt_q, cnt_d;
  logic [ACC_SIZE-1:0]                  acc_q, acc_d;
  logic                                 s1_vld_q, s1_vld_d;
  logic [ARRAY_SIZE-1:0][IN_SIZE_0-1:0] arr0_q, arr0_d;
  logic [ARRAY_SIZE-1:0][IN_SIZE_1-1:0] arr1_q, arr1_d;

  logic [LEN_W-1:0]    len_clamp;
  logic [PP_SIZE-1:0]  lane_prod;
  logic [SUM_W-1:0]    beat_sum;
  logic [ACC_SIZE-1:0] acc_next;

  // A lane's PPs summed modulo 2^PP_SIZE give its exact signed product.
  always_comb begin
    beat_sum  = '0;
    lane_prod = '0;
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      lane_prod = '0;
      for (int k = 0; k < PP_PER_MUL; k++) begin
        lane_prod = lane_prod + arr_pp_i[i*PP_PER_MUL + k];
      end
      beat_sum = beat_sum + {{(SUM_W-PP_SIZE){lane_prod[PP_SIZE-1]}}, lane_prod};
    end
  end

`ifdef ACC_SAT_EN
  logic [SUM_W-1:0] acc_sum;
  logic             acc_ovf;
  always_comb begin
    acc_sum  = {{(SUM_W-ACC_SIZE){acc_q[ACC_SIZE-1]}}, acc_q} + beat_sum;
    // In range only when every bit from the ACC sign bit upward agrees.
    acc_ovf  = !((&acc_sum[SUM_W-1:ACC_SIZE-1]) || !(|acc_sum[SUM_W-1:ACC_SIZE-1]));
    acc_next = acc_sum[ACC_SIZE-1:0];
    if (acc_ovf) begin
      acc_next = acc_sum[SUM_W-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}} : {1'b0, {(ACC_SIZE-1){1'b1}}};
    end
  end
`else
  always_comb acc_next = acc_q + beat_sum;
`endif

  always_comb begin
    len_clamp = (bus.job_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.job_len_i;
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    acc_d     = s1_vld_q ? acc_next : acc_q;
    s1_vld_d  = 1'b0;
    arr0_d    = arr0_q;
    arr1_d    = arr1_q;
    case (state_q)
      S_IDLE: begin
        if (bus.job_valid_i) begin
          len_d   = len_clamp;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = (len_clamp == '0) ? S_DONE : S_FEED;
        end
      end
      S_FEED: begin
        if (bus.op_valid_i) begin
          arr0_d   = bus.op_0_i;
          arr1_d   = bus.op_1_i;
          s1_vld_d = 1'b1;
          cnt_d    = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE: begin
        if (bus.res_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      s1_vld_q <= 1'b0;
      arr0_q   <= '0;
      arr1_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      s1_vld_q <= s1_vld_d;
      arr0_q   <= arr0_d;
      arr1_q   <= arr1_d;
    end
  end

  assign bus.job_ready_o = (state_q == S_IDLE);
  assign bus.op_ready_o  = (state_q == S_FEED);
  assign bus.res_valid_o = (state_q == S_DONE);
  assign bus.res_data_o  = (state_q == S_DONE) ? acc_q : '0;
  assign arr_in_0_o      = arr0_q;
  assign arr_in_1_o      = arr1_q;
  assign busy_o          = (state_q != S_IDLE);
  assign dbg_state_o     = state_q;
endmodule
